// File: rtl/reg_rot_seq.sv
`default_nettype none
// ============================================================================
// reg_rot_seq : write-port sequencer for a three-entry register bank
// Rev 1.0     : LOAD / SWAP / ROTL / ROTR via private temp register
// ============================================================================
module reg_rot_seq #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT0 = WIDTH'(1),
  parameter logic [WIDTH-1:0] INIT1 = WIDTH'(0),
  parameter logic [WIDTH-1:0] INIT2 = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_idx,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] C_OP_LOAD = 2'b00;
  localparam logic [1:0] C_OP_SWAP = 2'b01;
  localparam logic [1:0] C_OP_ROTL = 2'b10;
  localparam logic [1:0] C_OP_ROTR = 2'b11;
  localparam logic [1:0] C_IDX_BAD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_M1   = 2'd1,
    S_M2   = 2'd2,
    S_M3   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       ptn_q, ptn_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [WIDTH-1:0] bank_q [3];
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Single bank write port: every move funnels through these three signals.
  logic             w_wr_en;
  logic [1:0]       w_wr_sel;
  logic [WIDTH-1:0] w_wr_data;

  logic w_accept;
  assign w_accept = cmd_valid && (state_q == S_IDLE);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    ptn_d     = ptn_q;
    tmp_d     = tmp_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_sel  = 2'd0;
    w_wr_data = '0;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          op_d  = cmd_op;
          idx_d = cmd_idx;
          ptn_d = (cmd_idx == 2'd2) ? 2'd0 : cmd_idx + 2'd1;
          case (cmd_op)
            C_OP_LOAD: begin
              done_d = 1'b1;
              if (cmd_idx == C_IDX_BAD) begin
                err_d = 1'b1;
              end else begin
                w_wr_en   = 1'b1;
                w_wr_sel  = cmd_idx;
                w_wr_data = cmd_data;
              end
            end
            C_OP_SWAP: begin
              if (cmd_idx == C_IDX_BAD) begin
                done_d = 1'b1;
                err_d  = 1'b1;
              end else begin
                tmp_d   = bank_q[cmd_idx];
                state_d = S_M1;
              end
            end
            C_OP_ROTL: begin
              tmp_d   = bank_q[0];
              state_d = S_M1;
            end
            default: begin
              tmp_d   = bank_q[2];
              state_d = S_M1;
            end
          endcase
        end
      end

      S_M1: begin
        w_wr_en = 1'b1;
        state_d = S_M2;
        case (op_q)
          C_OP_SWAP: begin
            w_wr_sel  = idx_q;
            w_wr_data = bank_q[ptn_q];
          end
          C_OP_ROTL: begin
            w_wr_sel  = 2'd0;
            w_wr_data = bank_q[1];
          end
          C_OP_ROTR: begin
            w_wr_sel  = 2'd2;
            w_wr_data = bank_q[1];
          end
          default: begin
            w_wr_en = 1'b0;
            state_d = S_IDLE;
          end
        endcase
      end

      S_M2: begin
        w_wr_en = 1'b1;
        case (op_q)
          C_OP_SWAP: begin
            w_wr_sel  = ptn_q;
            w_wr_data = tmp_q;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end
          C_OP_ROTL: begin
            w_wr_sel  = 2'd1;
            w_wr_data = bank_q[2];
            state_d   = S_M3;
          end
          C_OP_ROTR: begin
            w_wr_sel  = 2'd1;
            w_wr_data = bank_q[0];
            state_d   = S_M3;
          end
          default: begin
            w_wr_en = 1'b0;
            state_d = S_IDLE;
          end
        endcase
      end

      S_M3: begin
        state_d = S_IDLE;
        if (op_q == C_OP_ROTL || op_q == C_OP_ROTR) begin
          w_wr_en   = 1'b1;
          w_wr_sel  = (op_q == C_OP_ROTL) ? 2'd2 : 2'd0;
          w_wr_data = tmp_q;
          done_d    = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Reset has priority over any accept, and aborts an in-flight sequence silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= C_OP_LOAD;
      idx_q     <= 2'd0;
      ptn_q     <= 2'd0;
      tmp_q     <= '0;
      bank_q[0] <= INIT0;
      bank_q[1] <= INIT1;
      bank_q[2] <= INIT2;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      ptn_q   <= ptn_d;
      tmp_q   <= tmp_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (w_wr_en) begin
        bank_q[w_wr_sel] <= w_wr_data;
      end
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = !cmd_ready;
  assign done      = done_q;
  assign err       = err_q;
  assign q0        = bank_q[0];
  assign q1        = bank_q[1];
  assign q2        = bank_q[2];

endmodule
`default_nettype wire

// File: tb/tb_reg_rot_seq.sv
`default_nettype none
// ============================================================================
// tb_reg_rot_seq : directed bench with a command-level reference model
// Rev 1.0
// ============================================================================
module tb_reg_rot_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [1:0]       cmd_idx;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] q0, q1, q2;
  logic             busy, done, err;

  reg_rot_seq #(
    .WIDTH(WIDTH),
    .INIT0(8'd1),
    .INIT1(8'd0),
    .INIT2(8'd1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_idx  (cmd_idx),
    .cmd_data (cmd_data),
    .q0       (q0),
    .q1       (q1),
    .q2       (q2),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command-level model: final contents applied as one parallel assignment
  // when the command's latency expires; intermediate values are not modelled.
  logic [7:0] m [3];
  logic [7:0] f [3];
  int         m_cnt      = 0;
  logic       m_done     = 1'b0;
  logic       m_err      = 1'b0;
  logic       m_rst_edge = 1'b1;

  always @(posedge clk) begin
    logic acc;
    acc        = cmd_valid && (m_cnt == 0);
    m_rst_edge = reset;
    m_done     = 1'b0;
    m_err      = 1'b0;
    if (reset) begin
      m[0] = 8'd1; m[1] = 8'd0; m[2] = 8'd1;
      m_cnt = 0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m = f;
        end
      end
      if (acc) begin
        if (cmd_op <= 2'd1 && cmd_idx == 2'd3) begin
          m_done = 1'b1;
          m_err  = 1'b1;
        end else if (cmd_op == 2'd0) begin
          m[cmd_idx] = cmd_data;
          m_done = 1'b1;
        end else if (cmd_op == 2'd1) begin
          f = m;
          f[cmd_idx] = m[(cmd_idx + 1) % 3];
          f[(cmd_idx + 1) % 3] = m[cmd_idx];
          m_cnt = 2;
        end else if (cmd_op == 2'd2) begin
          f[0] = m[1]; f[1] = m[2]; f[2] = m[0];
          m_cnt = 3;
        end else begin
          f[0] = m[2]; f[1] = m[0]; f[2] = m[1];
          m_cnt = 3;
        end
      end
    end
  end

  logic       chk_en = 1'b0;
  logic [7:0] pq0, pq1, pq2;

  always @(negedge clk) begin
    int nchg;
    if (chk_en) begin
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_cnt == 0});
      chk("busy",      {31'd0, busy},      {31'd0, m_cnt != 0});
      chk("done",      {31'd0, done},      {31'd0, m_done});
      chk("err",       {31'd0, err},       {31'd0, m_err});
      if (m_cnt == 0) begin
        chk("q0_model", {24'd0, q0}, {24'd0, m[0]});
        chk("q1_model", {24'd0, q1}, {24'd0, m[1]});
        chk("q2_model", {24'd0, q2}, {24'd0, m[2]});
      end
      if (!m_rst_edge) begin
        nchg = int'(q0 != pq0) + int'(q1 != pq1) + int'(q2 != pq2);
        chk("single_write", nchg, 1 < nchg ? 1 : nchg);
      end
    end
    pq0 = q0; pq1 = q1; pq2 = q2;
  end

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [1:0] idx, input logic [7:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_data = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_q(input string name, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    chk({name, "_q0"}, {24'd0, q0}, {24'd0, e0});
    chk({name, "_q1"}, {24'd0, q1}, {24'd0, e1});
    chk({name, "_q2"}, {24'd0, q2}, {24'd0, e2});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2;
    // Reset with a simultaneous command: reset must win.
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_idx = 2'd0; cmd_data = 8'h77;
    repeat (3) @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0;
    chk_en = 1'b1;
    chk_q("reset", 8'h01, 8'h00, 8'h01);
    chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_done",  {31'd0, done},      32'd0);
    @(negedge clk);

    issue(2'd2, 2'd0, 8'h00);
    wait_done(c);
    chk("lat_rotl", c, 4);
    chk_q("rotl", 8'h00, 8'h01, 8'h01);

    issue(2'd0, 2'd0, 8'hA5);
    chk("load0_done", {31'd0, done}, 32'd1);
    issue(2'd0, 2'd1, 8'h3C);
    chk("load1_done", {31'd0, done}, 32'd1);
    issue(2'd0, 2'd2, 8'h0F);
    chk("load2_done", {31'd0, done}, 32'd1);
    chk_q("loads", 8'hA5, 8'h3C, 8'h0F);

    issue(2'd1, 2'd2, 8'h00);
    wait_done(c);
    chk("lat_swap", c, 3);
    chk_q("swap2", 8'h0F, 8'h3C, 8'hA5);

    issue(2'd3, 2'd0, 8'h00);
    wait_done(c);
    chk("lat_rotr", c, 4);
    chk_q("rotr", 8'hA5, 8'h0F, 8'h3C);

    issue(2'd1, 2'd3, 8'h00);
    chk("ill_done", {31'd0, done}, 32'd1);
    chk("ill_err",  {31'd0, err},  32'd1);
    @(negedge clk);
    chk("ill_done_off", {31'd0, done}, 32'd0);
    chk("ill_err_off",  {31'd0, err},  32'd0);
    chk_q("ill", 8'hA5, 8'h0F, 8'h3C);

    // LOAD held during M1 and M2 of a SWAP must be dropped, not buffered.
    issue(2'd1, 2'd1, 8'h00);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_idx = 2'd0; cmd_data = 8'h55;
    chk("busy_m1_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("busy_m2_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("swap1_done", {31'd0, done}, 32'd1);
    chk_q("swap1", 8'hA5, 8'h3C, 8'h0F);
    @(negedge clk);

    // Reset during M2 aborts the rotate.
    issue(2'd2, 2'd0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_q("abort", 8'h01, 8'h00, 8'h01);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_done",  {31'd0, done},      32'd0);
    @(negedge clk);
    chk("abort_done2", {31'd0, done}, 32'd0);
    issue(2'd0, 2'd1, 8'hFF);
    chk("ldff_done", {31'd0, done}, 32'd1);
    chk_q("ldff", 8'h01, 8'hFF, 8'h01);

    // ROTL then ROTR accepted in the ROTL done cycle.
    issue(2'd0, 2'd0, 8'h11);
    issue(2'd0, 2'd1, 8'h22);
    issue(2'd0, 2'd2, 8'h33);
    issue(2'd2, 2'd0, 8'h00);
    wait_done(c);
    chk_q("rr_mid", 8'h22, 8'h33, 8'h11);
    issue(2'd3, 2'd0, 8'h00);
    wait_done(c2);
    chk("rr_total", c + c2, 8);
    chk_q("rr_end", 8'h11, 8'h22, 8'h33);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_rot_seq.md
# reg_rot_seq

Sequencer for a three-entry register bank (R0, R1, R2) that owns the bank's single write port. It accepts load, swap and rotate commands over a valid/ready handshake and executes each as a fixed sequence of one-register-per-cycle moves through a private temp register. The result is always the parallel-assignment outcome, with no read-after-write hazards between the moves. It sits between a command source (testbench or control FSM) and any logic that reads the bank through q0..q2.

## Interface
- WIDTH, 8, bit width of each bank entry and TMP
- INIT0, 1, reset value of R0
- INIT1, 0, reset value of R1
- INIT2, 1, reset value of R2

- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command this cycle
- cmd_op  input  2  00 LOAD, 01 SWAP, 10 ROTL, 11 ROTR
- cmd_idx  input  2  target index 0..2 (LOAD/SWAP); 3 illegal; ignored for ROTL/ROTR
- cmd_data  input  WIDTH  LOAD data
- q0, q1, q2  output  WIDTH  registered bank contents R0, R1, R2
- busy  output  1  equals !cmd_ready
- done  output  1  one-cycle pulse: command's final write is visible on q*
- err  output  1  one-cycle pulse, coincident with done, for an illegal cmd_idx

## Operation
- Reset values: R0=INIT0, R1=INIT1, R2=INIT2, TMP=0, state IDLE, cmd_ready=1, busy=0, done=0, err=0.
- Accept = cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. Inputs are sampled only at the accept edge.
- States: IDLE, M1, M2, M3. The op, index and partner index are latched at accept.
- Write-port rule: at most one of R0..R2 changes on any edge.
- LOAD i:
  - Accept edge: R[i]<=cmd_data; done=1 next cycle; stay IDLE.
  - Back-to-back LOADs are allowed, one per cycle.
- SWAP i (partner j=(i+1) mod 3):
  - Accept edge: TMP<=R[i], go to M1.
  - M1: R[i]<=R[j], go to M2.
  - M2: R[j]<=TMP, done, go to IDLE.
- ROTL (result R0=old R1, R1=old R2, R2=old R0):
  - Accept edge: TMP<=R0.
  - M1: R0<=R1.
  - M2: R1<=R2.
  - M3: R2<=TMP, done, go to IDLE.
- ROTR (result R0=old R2, R1=old R0, R2=old R1):
  - Accept edge: TMP<=R2.
  - M1: R2<=R1.
  - M2: R1<=R0.
  - M3: R0<=TMP, done, go to IDLE.
- Illegal cmd_idx=3 with LOAD or SWAP: accepted, no bank or TMP change, done=err=1 next cycle, stay IDLE.
- cmd_valid while busy: ignored, no buffering. The source must hold the command until ready.

## Timing
- Latency from accept edge to done-high cycle: LOAD 1, SWAP 3, ROTL/ROTR 4 cycles. Illegal commands take 1 cycle.
- Intermediate q* values during M1..M3 are visible and carry no guarantee beyond the single-write rule.
- cmd_ready returns high in the same cycle done is high, so the next command can be accepted in that cycle: throughput is 1 command per latency.
- done and err are registered. They are low in every cycle except the one following the final write edge.
- Reset during M1..M3 aborts the sequence with no completion: the bank returns to INIT values, done stays 0, cmd_ready=1 on the next cycle.
- Reset and cmd_valid in the same cycle: reset wins and the command is not accepted.

## Test plan
- Reset (defaults): q0=1, q1=0, q2=1, cmd_ready=1, done=0. Then ROTL -> done 4 cycles after accept; q0=0, q1=1, q2=1.
- LOAD 0=0xA5, LOAD 1=0x3C, LOAD 2=0x0F on consecutive cycles -> three consecutive done pulses; final q=A5,3C,0F; cmd_ready never drops.
- From A5,3C,0F:
  - SWAP 2 (partner 0) -> done 3 cycles later; q=0F,3C,A5.
  - Then ROTR -> q=A5,0F,3C.
  - Every cycle, check that at most one q changes.
- SWAP with idx=3 -> err=done=1 for exactly 1 cycle; q unchanged; a LOAD presented meanwhile while busy is ignored.
- ROTL accepted, reset asserted in M2 -> next cycle q=1,0,1, done never pulses, cmd_ready=1; a following LOAD 1=0xFF is accepted normally.
- ROTL followed immediately by ROTR, with the second command accepted in the done cycle -> contents restored to pre-ROTL values after 8 cycles.
